vector_banked_data_memory: RTL
==============================

// Module: vector_banked_data_memory
// PURPOSE
//  Parametrised banked data memory for the vector ASIP datapath. Serves scalar and NUM_LANES-wide vector
//  loads/stores of ELEM_W-bit elements, each zero-extended into a LANE_W-bit lane. Sits between the MEM
//  stage and the image/alpha buffers. Adds a req/rsp handshake, bank-crossing split accesses and an error flag.
// PARAMETERS
//  NUM_LANES   4      elements per vector access (lane i addresses addr+i)
//  ELEM_W      8      stored element width, bits
//  LANE_W      32     lane width on wdata/rdata, bits; ELEM_W <= LANE_W
//  BANK_DEPTH  16384  elements per bank; power of two
//  NUM_BANKS   12     number of banks
//  ADDR_W      32     element address width
// PORTS
//  clk        in   1                 clock; all state updates on posedge
//  rst        in   1                 synchronous, active-high reset
//  req_valid  in   1                 request present
//  req_ready  out  1                 request accepted when req_valid && req_ready
//  req_we     in   1                 1 = store, 0 = load
//  req_vf     in   1                 1 = vector (all lanes), 0 = scalar (lane 0 only)
//  req_addr   in   ADDR_W            element address of lane 0
//  req_wdata  in   NUM_LANES*LANE_W  store data; lane i = bits [i*LANE_W +: ELEM_W]
//  rsp_valid  out  1                 one-cycle pulse per accepted request
//  rsp_rdata  out  NUM_LANES*LANE_W  load data, zero-extended per lane; all zeros for stores
//  rsp_err    out  1                 valid with rsp_valid; any addressed lane was out of range
// BEHAVIOUR
//  - Reset: req_ready=0 during rst, 1 on the first cycle after; rsp_valid=0, rsp_rdata=0, rsp_err=0, FSM=IDLE.
//    Memory contents are not reset.
//  - Address map: bank = addr / BANK_DEPTH, offset = addr % BANK_DEPTH. Range is addr < NUM_BANKS*BANK_DEPTH.
//  - Out-of-range lane: store ignored, load returns 0, sets rsp_err.
//  - Scalar access: lane 0 only. Other rsp lanes are 0 and other wdata lanes are ignored.
//  - FSM IDLE: req_ready=1.
//    - Accepted request with all lanes in one bank (or scalar): access all lanes; rsp_valid at T+1.
//    - Accepted vector request crossing a bank boundary (offset+NUM_LANES-1 >= BANK_DEPTH):
//      - cycle T: serve the lanes in the first bank; latch the request; go to SPLIT.
//  - FSM SPLIT: req_ready=0. Serve the remaining lanes in the next bank; return to IDLE.
//    rsp_valid at T+2 with the merged lanes.
//  - Read-before-write: a store returns nothing. A load issued the cycle after a store to the same address
//    sees the new data.
//  - Address arithmetic is done in ADDR_W+1 bits. Lanes wrapping past 2^ADDR_W are out of range, never aliased.
//  - rst asserted mid-SPLIT: FSM->IDLE, pending response dropped (no rsp_valid). Lanes already stored stay written.
//  - rsp has no backpressure; the consumer must accept every rsp_valid.
// CONFIGURATION
//  VDM_GPIO_MIRROR_EN defined: extra outputs
//    - gpio_data [NUM_LANES*ELEM_W]
//    - gpio_en_r, gpio_en_g, gpio_en_b
//  Each is registered and pulses 1 cycle after every in-range store.
//    - Channel select: bank/(NUM_BANKS/3) -> R, G, B.
//    - gpio_data carries the stored elements packed (scalar: lane 0, upper bits 0).
//    - A split store mirrors each half in its own cycle.
//    - All four outputs reset to 0.
//  Macro undefined: ports absent, no mirror logic.
// STRUCTURE
//  Package vdm_pkg:
//    - state_t {IDLE, SPLIT}
//    - lane_mask_t
//    - helper function bank_of()
//  Sub-module vdm_bank: one BANK_DEPTH x ELEM_W array with per-lane write enables and NUM_LANES read ports.
//  Top instantiates NUM_BANKS copies via generate, plus the FSM and lane router.
// TESTING (bench: NUM_LANES=4, ELEM_W=8, LANE_W=32, BANK_DEPTH=16, NUM_BANKS=3)
//  1 Reset, then vector store addr=4 wdata lanes {0x44,0x33,0x22,0x11}; vector load addr=4
//    -> rdata=0x00000044_00000033_00000022_00000011, err=0, rsp_valid 1 cycle after accept.
//  2 Vector store addr=14 {D,C,B,A}=0xDD,0xCC,0xBB,0xAA
//    -> req_ready low 1 cycle, rsp at T+2.
//    Then scalar loads 14..17 -> 0xAA, 0xBB, 0xCC, 0xDD.
//  3 Vector load addr=46 -> lanes 0,1 = stored data, lanes 2,3 = 0, rsp_err=1. Scalar store addr=48 -> err=1, no write.
//  4 Scalar store addr=0 wdata=0xFFFFFF5A -> scalar load addr=0 returns 0x0000005A; lanes 1..3 = 0.
//  5 rst asserted in the SPLIT cycle of a load at addr=15 -> no rsp_valid; req_ready=1 on the cycle after rst deasserts.
//  6 (VDM_GPIO_MIRROR_EN) Scalar store addr=20 wdata=0x77 -> next cycle gpio_en_g=1, gpio_data[7:0]=0x77, others 0.

Source files
------------

// File: rtl/vdm_pkg.sv
// rtl/vdm_pkg.sv - shared types and helpers for the vector banked data memory
// Purpose: FSM state type, lane mask type and the address-to-bank helper
// used by vector_banked_data_memory and vdm_bank.
// Ports: none (package).
package vdm_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } state_t;

  localparam int unsigned VDM_DEFAULT_LANES = 4;

  // Lane mask for the default lane count; the top sizes its masks from NUM_LANES.
  typedef logic [VDM_DEFAULT_LANES-1:0] lane_mask_t;

  // Bank index of an element address; banks are power-of-two deep, so this is a shift.
  function automatic int unsigned bank_of(input logic [63:0] addr, input int unsigned off_w);
    return 32'(addr >> off_w);
  endfunction

endpackage

// File: rtl/vdm_bank.sv
// rtl/vdm_bank.sv - one element-wide memory bank with a port per vector lane
// Purpose: BANK_DEPTH x ELEM_W storage. Each lane has its own write enable and
// shares its address between write and asynchronous read.
// Ports:
//   clk      clock, writes on posedge
//   we_i     per-lane write enable
//   addr_i   per-lane element offset inside the bank
//   wdata_i  per-lane write element
//   rdata_o  per-lane read element (combinational from addr_i)
module vdm_bank #(
  parameter int unsigned NUM_LANES  = 4,
  parameter int unsigned ELEM_W     = 8,
  parameter int unsigned BANK_DEPTH = 16384
) (
  input  logic                                         clk,
  input  logic [NUM_LANES-1:0]                         we_i,
  input  logic [NUM_LANES-1:0][$clog2(BANK_DEPTH)-1:0] addr_i,
  input  logic [NUM_LANES-1:0][ELEM_W-1:0]             wdata_i,
  output logic [NUM_LANES-1:0][ELEM_W-1:0]             rdata_o
);

  logic [ELEM_W-1:0] mem [BANK_DEPTH];

  // Lanes of one access hit consecutive offsets, so enabled lanes never collide.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (we_i[i]) begin
        mem[addr_i[i]] <= wdata_i[i];
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      rdata_o[i] = mem[addr_i[i]];
    end
  end

endmodule

// File: rtl/vector_banked_data_memory.sv
// rtl/vector_banked_data_memory.sv - banked scalar/vector data memory with split bank-crossing accesses
// Purpose: serves scalar and NUM_LANES-wide loads/stores of ELEM_W-bit elements,
// zero-extended into LANE_W-bit lanes. A vector access that crosses a bank
// boundary is served over two cycles (IDLE then SPLIT) and answered once with
// the merged lanes. Out-of-range lanes are not written, read as 0 and raise rsp_err.
// Optional build macro VDM_GPIO_MIRROR_EN adds a registered mirror of every
// in-range store on gpio_data / gpio_en_r / gpio_en_g / gpio_en_b.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   req_valid/req_ready  request handshake
//   req_we, req_vf       store / vector selects
//   req_addr             element address of lane 0
//   req_wdata            store data, element i in bits [i*LANE_W +: ELEM_W]
//   rsp_valid            one-cycle pulse per accepted request
//   rsp_rdata            load data per lane, zero for stores
//   rsp_err              some addressed lane was out of range
//   gpio_*               (VDM_GPIO_MIRROR_EN only) store mirror outputs
module vector_banked_data_memory
  import vdm_pkg::*;
#(
  parameter int unsigned NUM_LANES  = 4,
  parameter int unsigned ELEM_W     = 8,
  parameter int unsigned LANE_W     = 32,
  parameter int unsigned BANK_DEPTH = 16384,
  parameter int unsigned NUM_BANKS  = 12,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_we,
  input  logic                        req_vf,
  input  logic [ADDR_W-1:0]           req_addr,
  input  logic [NUM_LANES*LANE_W-1:0] req_wdata,
  output logic                        rsp_valid,
  output logic [NUM_LANES*LANE_W-1:0] rsp_rdata,
  output logic                        rsp_err
`ifdef VDM_GPIO_MIRROR_EN
  ,
  output logic [NUM_LANES*ELEM_W-1:0] gpio_data,
  output logic                        gpio_en_r,
  output logic                        gpio_en_g,
  output logic                        gpio_en_b
`endif
);

  localparam int unsigned OFF_W = $clog2(BANK_DEPTH);
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(NUM_BANKS * BANK_DEPTH);

  state_t                              state_q, state_d;
  logic                                lat_we_q;
  logic [ADDR_W-1:0]                   lat_addr_q;
  logic [NUM_LANES-1:0][ELEM_W-1:0]    lat_elem_q;
  logic [NUM_LANES-1:0]                done_q;
  logic [NUM_LANES-1:0][LANE_W-1:0]    part_rdata_q;
  logic                                part_err_q;
  logic                                rsp_valid_q, rsp_valid_d;
  logic [NUM_LANES-1:0][LANE_W-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic                                rsp_err_q, rsp_err_d;

  logic                                in_split, accept, crossing;
  logic                                cur_we, cur_vf;
  logic [ADDR_W-1:0]                   cur_addr;
  logic [OFF_W-1:0]                    off0;
  logic [NUM_LANES-1:0][ELEM_W-1:0]    req_elem, cur_elem;
  logic [ADDR_W:0]                     lane_addr [NUM_LANES];
  logic [NUM_LANES-1:0][OFF_W-1:0]     lane_off;
  int unsigned                         lane_bank [NUM_LANES];
  logic [NUM_LANES-1:0]                in_range, active, first, serve;
  logic [NUM_LANES-1:0][LANE_W-1:0]    lane_rd;
  logic                                err_now;
  logic [NUM_LANES-1:0]                bank_we    [NUM_BANKS];
  logic [NUM_LANES-1:0][ELEM_W-1:0]    bank_rdata [NUM_BANKS];

  // Only the low ELEM_W bits of each wdata lane are stored.
  logic unused_wdata;
  assign unused_wdata = ^req_wdata;

  // Combinational on rst so the port reads 1 on the very first cycle after reset.
  assign req_ready = (state_q == IDLE) && !rst;
  assign in_split  = (state_q == SPLIT);
  assign accept    = req_valid && req_ready;

  always_comb begin
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      req_elem[i] = req_wdata[i*LANE_W +: ELEM_W];
    end
  end

  // In SPLIT the latched request drives the lane router instead of the ports.
  assign cur_we   = in_split ? lat_we_q   : req_we;
  assign cur_vf   = in_split ? 1'b1       : req_vf;
  assign cur_addr = in_split ? lat_addr_q : req_addr;
  assign cur_elem = in_split ? lat_elem_q : req_elem;
  assign off0     = cur_addr[OFF_W-1:0];
  assign crossing = cur_vf && (32'(off0) + NUM_LANES - 1 >= BANK_DEPTH);

  always_comb begin
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      // One extra bit keeps lanes past 2^ADDR_W out of range instead of aliasing to 0.
      lane_addr[i] = {1'b0, cur_addr} + (ADDR_W+1)'(i);
      in_range[i]  = lane_addr[i] < ADDR_LIMIT;
      lane_off[i]  = lane_addr[i][OFF_W-1:0];
      lane_bank[i] = bank_of(64'(lane_addr[i]), OFF_W);
      active[i]    = cur_vf || (i == 0);
      first[i]     = active[i] && (32'(off0) + i < BANK_DEPTH);
      if (rst) begin
        serve[i] = 1'b0;
      end else if (in_split) begin
        serve[i] = active[i] && !done_q[i];
      end else begin
        serve[i] = accept && first[i];
      end
    end
  end

  always_comb begin
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      bank_we[b] = '0;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        bank_we[b][i] = serve[i] && cur_we && in_range[i] && (lane_bank[i] == b);
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    vdm_bank #(
      .NUM_LANES  (NUM_LANES),
      .ELEM_W     (ELEM_W),
      .BANK_DEPTH (BANK_DEPTH)
    ) u_bank (
      .clk     (clk),
      .we_i    (bank_we[b]),
      .addr_i  (lane_off),
      .wdata_i (cur_elem),
      .rdata_o (bank_rdata[b])
    );
  end

  // Unserved, out-of-range and store lanes read as 0 so halves merge with a plain OR.
  always_comb begin
    logic [ELEM_W-1:0] sel;
    err_now = 1'b0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      sel = '0;
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        if (lane_bank[i] == b) begin
          sel = bank_rdata[b][i];
        end
      end
      lane_rd[i] = '0;
      if (serve[i] && in_range[i] && !cur_we) begin
        lane_rd[i] = LANE_W'(sel);
      end
      if (serve[i] && !in_range[i]) begin
        err_now = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (crossing) begin
            state_d = SPLIT;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = lane_rd;
            rsp_err_d   = err_now;
          end
        end
      end
      SPLIT: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = part_rdata_q | lane_rd;
        rsp_err_d   = part_err_q | err_now;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      done_q       <= '0;
      part_rdata_q <= '0;
      part_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      if (!in_split && accept) begin
        lat_we_q     <= req_we;
        lat_addr_q   <= req_addr;
        lat_elem_q   <= req_elem;
        done_q       <= first;
        part_rdata_q <= lane_rd;
        part_err_q   <= err_now;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

`ifdef VDM_GPIO_MIRROR_EN
  logic [NUM_LANES-1:0]             st_mask;
  logic [NUM_LANES-1:0][ELEM_W-1:0] gpio_data_q, gpio_data_d;
  logic                             gpio_en_r_q, gpio_en_g_q, gpio_en_b_q;
  logic                             gpio_en_r_d, gpio_en_g_d, gpio_en_b_d;
  int unsigned                      st_bank, st_chan;

  // Every lane stored in one cycle sits in the same bank; take the lowest one.
  always_comb begin
    st_bank = 0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      st_mask[i]     = serve[i] && in_range[i] && cur_we;
      gpio_data_d[i] = st_mask[i] ? cur_elem[i] : '0;
      if (st_mask[i]) begin
        st_bank = lane_bank[i];
      end
    end
    st_chan     = st_bank / (NUM_BANKS / 3);
    gpio_en_r_d = (|st_mask) && (st_chan == 0);
    gpio_en_g_d = (|st_mask) && (st_chan == 1);
    gpio_en_b_d = (|st_mask) && (st_chan >= 2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_data_q <= '0;
      gpio_en_r_q <= 1'b0;
      gpio_en_g_q <= 1'b0;
      gpio_en_b_q <= 1'b0;
    end else begin
      gpio_data_q <= gpio_data_d;
      gpio_en_r_q <= gpio_en_r_d;
      gpio_en_g_q <= gpio_en_g_d;
      gpio_en_b_q <= gpio_en_b_d;
    end
  end

  assign gpio_data = gpio_data_q;
  assign gpio_en_r = gpio_en_r_q;
  assign gpio_en_g = gpio_en_g_q;
  assign gpio_en_b = gpio_en_b_q;
`endif

endmodule
